// File: rtl/cplx_dly_pkg.sv
// Shared constants and helpers for the complex-sample delay line.
// Optional build macro used by the top: CPLX_DLY_PRIME_ZERO_EN.
package cplx_dly_pkg;

   localparam int DEF_DATA_W    = 32;
   localparam int DEF_CHANNELS  = 2;
   localparam int DEF_MAX_DEPTH = 32;

   // Requested delay of 0 means 1; anything above the RAM depth saturates.
   function automatic int unsigned clamp_delay(input int unsigned d, input int unsigned max_depth);
      if (d == 0)
         return 1;
      else if (d > max_depth)
         return max_depth;
      else
         return d;
   endfunction

   // LSB of lane k inside a packed CHANNELS*DATA_W vector.
   function automatic int unsigned lane_lsb(input int unsigned lane, input int unsigned data_w);
      return lane * data_w;
   endfunction

endpackage

// File: rtl/cplx_dly_ram.sv
// Simple dual-port RAM, read-first, synchronous read with read enable.
// No reset: contents and the read register are only meaningful once written/read.
module cplx_dly_ram #(
   parameter int WIDTH = 128,
   parameter int DEPTH = 32,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             i_wr_en,
   input  logic [AW-1:0]    i_wr_addr,
   input  logic [WIDTH-1:0] i_wr_data,
   input  logic             i_rd_en,
   input  logic [AW-1:0]    i_rd_addr,
   output logic [WIDTH-1:0] o_rd_data
);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [WIDTH-1:0] r_rd_data;

   // Non-blocking write and read in one process give read-first on address collision.
   always_ff @(posedge clk) begin
      if (i_wr_en)
         r_mem[i_wr_addr] <= i_wr_data;
      if (i_rd_en)
         r_rd_data <= r_mem[i_rd_addr];
   end

   assign o_rd_data = r_rd_data;

endmodule

// File: rtl/cplx_delay_line.sv
// Valid-qualified circular-buffer delay line for CHANNELS complex lanes.
// Define CPLX_DLY_PRIME_ZERO_EN to emit zeros (out_valid high) while priming.
module cplx_delay_line
   import cplx_dly_pkg::*;
#(
   parameter  int DATA_W    = DEF_DATA_W,
   parameter  int CHANNELS  = DEF_CHANNELS,
   parameter  int MAX_DEPTH = DEF_MAX_DEPTH,
   localparam int PTR_W     = $clog2(MAX_DEPTH)
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       in_valid,
   input  logic [CHANNELS*DATA_W-1:0] in_re,
   input  logic [CHANNELS*DATA_W-1:0] in_im,
   input  logic [PTR_W:0]             delay,
   output logic                       out_valid,
   output logic [CHANNELS*DATA_W-1:0] out_re,
   output logic [CHANNELS*DATA_W-1:0] out_im,
   output logic                       primed
);

   localparam int CW = CHANNELS * DATA_W;
   localparam int WW = 2 * CW;

   logic [PTR_W-1:0] r_wr_ptr;
   logic [PTR_W:0]   r_de_q;
   logic [PTR_W:0]   r_fill_cnt;
   logic             r_out_valid;
   logic             r_rd_live;
   logic             r_rd_zero;

   logic [PTR_W:0]   w_de_clamp;
   logic             w_de_change;
   logic             w_primed;
   logic [PTR_W:0]   w_wr_ext;
   logic [PTR_W:0]   w_rd_sum;
   logic [PTR_W-1:0] w_rd_addr;
   logic [PTR_W-1:0] w_wr_ptr_inc;
   logic             w_wr_en;
   logic             w_rd_en;
   logic             w_out_keep;
   logic [WW-1:0]    w_wr_word;
   logic [WW-1:0]    w_rd_word;

   assign w_de_clamp  = (PTR_W+1)'(clamp_delay(32'(delay), MAX_DEPTH));
   assign w_de_change = (w_de_clamp != r_de_q);
   // A pending delay change already counts as unprimed in the cycle it is seen.
   assign w_primed    = !w_de_change && (r_fill_cnt == r_de_q);
   assign primed      = w_primed;

   assign w_wr_ext     = {1'b0, r_wr_ptr};
   assign w_rd_sum     = (w_wr_ext >= r_de_q) ? (w_wr_ext - r_de_q)
                                              : (w_wr_ext + (PTR_W+1)'(MAX_DEPTH) - r_de_q);
   assign w_rd_addr    = w_rd_sum[PTR_W-1:0];
   assign w_wr_ptr_inc = (r_wr_ptr == PTR_W'(MAX_DEPTH-1)) ? '0 : r_wr_ptr + PTR_W'(1);

   assign w_wr_en = in_valid && !rst;
`ifdef CPLX_DLY_PRIME_ZERO_EN
   assign w_rd_en = in_valid && !rst;
`else
   assign w_rd_en = in_valid && w_primed && !rst;
`endif

   assign w_wr_word = {in_re, in_im};

   cplx_dly_ram #(
      .WIDTH (WW),
      .DEPTH (MAX_DEPTH),
      .AW    (PTR_W)
   ) u_ram (
      .clk       (clk),
      .i_wr_en   (w_wr_en),
      .i_wr_addr (r_wr_ptr),
      .i_wr_data (w_wr_word),
      .i_rd_en   (w_rd_en),
      .i_rd_addr (w_rd_addr),
      .o_rd_data (w_rd_word)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         r_wr_ptr    <= '0;
         r_fill_cnt  <= '0;
         r_de_q      <= w_de_clamp;
         r_out_valid <= 1'b0;
         r_rd_live   <= 1'b0;
         r_rd_zero   <= 1'b0;
      end else begin
         if (in_valid)
            r_wr_ptr <= w_wr_ptr_inc;
         if (w_de_change) begin
            r_de_q     <= w_de_clamp;
            r_fill_cnt <= {{PTR_W{1'b0}}, in_valid};
         end else if (in_valid && (r_fill_cnt < r_de_q)) begin
            r_fill_cnt <= r_fill_cnt + (PTR_W+1)'(1);
         end
         r_out_valid <= w_rd_en;
         // The RAM read register holds between reads; these flags qualify what it shows.
         if (w_rd_en) begin
            r_rd_live <= 1'b1;
            r_rd_zero <= !w_primed;
         end
      end
   end

   assign out_valid  = r_out_valid;
   assign w_out_keep = r_rd_live && !r_rd_zero;

   for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_lane
      localparam int LSB = int'(lane_lsb(gi, DATA_W));
      assign out_re[LSB +: DATA_W] = w_out_keep ? w_rd_word[CW + LSB +: DATA_W] : '0;
      assign out_im[LSB +: DATA_W] = w_out_keep ? w_rd_word[LSB +: DATA_W]      : '0;
   end

endmodule

// File: tb/tb_cplx_delay_line.sv
// Directed bench for cplx_delay_line: streams, sparse-valid table, delay change, resets.
// Expectations adapt when CPLX_DLY_PRIME_ZERO_EN is defined.
module tb_cplx_delay_line;

   localparam int DATA_W    = 32;
   localparam int CHANNELS  = 2;
   localparam int MAX_DEPTH = 32;
   localparam int PTR_W     = $clog2(MAX_DEPTH);

   logic                       clk = 1'b0;
   logic                       rst = 1'b1;
   logic                       in_valid = 1'b0;
   logic [CHANNELS*DATA_W-1:0] in_re = '0;
   logic [CHANNELS*DATA_W-1:0] in_im = '0;
   logic [PTR_W:0]             delay = '0;
   logic                       out_valid;
   logic [CHANNELS*DATA_W-1:0] out_re;
   logic [CHANNELS*DATA_W-1:0] out_im;
   logic                       primed;

   cplx_delay_line #(
      .DATA_W    (DATA_W),
      .CHANNELS  (CHANNELS),
      .MAX_DEPTH (MAX_DEPTH)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_re     (in_re),
      .in_im     (in_im),
      .delay     (delay),
      .out_valid (out_valid),
      .out_re    (out_re),
      .out_im    (out_im),
      .primed    (primed)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic vld;
      int   val;
      int   dly;
      logic exp_pr;
      int   exp_out;
   } vec_t;

   vec_t        vecs [18];
   int          n_checks = 0;
   int          n_fail   = 0;
   logic [63:0] exp_re_last = '0;
   logic [63:0] exp_im_last = '0;

   function automatic logic [63:0] mk_re(input int v);
      return {32'(v + 1000), 32'(v)};
   endfunction

   function automatic logic [63:0] mk_im(input int v);
      return {32'(v * 3 + 7), 32'(-v)};
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic do_reset(input int dly, input logic v);
      rst      = 1'b1;
      in_valid = v;
      in_re    = mk_re(999);
      in_im    = mk_im(999);
      delay    = (PTR_W+1)'(dly);
      @(posedge clk);
      #1;
      rst      = 1'b0;
      in_valid = 1'b0;
      exp_re_last = '0;
      exp_im_last = '0;
      chk("reset_out_valid", 64'(out_valid), 64'(0));
      chk("reset_out_re", out_re, 64'(0));
      chk("reset_out_im", out_im, 64'(0));
      chk("reset_primed", 64'(primed), 64'(0));
      $display("reset delay=%0d out_valid=%0b primed=%0b", dly, out_valid, primed);
   endtask

   task automatic step(input logic v, input int val, input int dly,
                       input logic exp_pr, input int exp_out);
      logic ev;
      logic zero;
      in_valid = v;
      in_re    = mk_re(val);
      in_im    = mk_im(val);
      delay    = (PTR_W+1)'(dly);
      #1;
      chk("primed", 64'(primed), 64'(exp_pr));
      @(posedge clk);
      #1;
`ifdef CPLX_DLY_PRIME_ZERO_EN
      ev   = v;
      zero = !exp_pr;
`else
      ev   = v && exp_pr;
      zero = 1'b0;
`endif
      if (ev) begin
         exp_re_last = zero ? 64'(0) : mk_re(exp_out);
         exp_im_last = zero ? 64'(0) : mk_im(exp_out);
      end
      chk("out_valid", 64'(out_valid), 64'(ev));
      chk("out_re", out_re, exp_re_last);
      chk("out_im", out_im, exp_im_last);
      $display("vld=%0b in=%0d dly=%0d -> out_valid=%0b out_re0=%0d primed_before=%0b",
               v, val, dly, out_valid, $signed(out_re[31:0]), exp_pr);
   endtask

   // Continuous stream of samples first..last after a fresh (re)prime; de is the effective delay.
   task automatic stream(input int dly, input int de, input int first, input int last);
      for (int n = first; n <= last; n++) begin
         step(1'b1, n, dly, (n - first + 1) > de, n - de);
      end
   endtask

   initial begin
      // delay=4 with sparse valids: samples 10..16
      vecs[0]  = '{1'b1, 10, 4, 1'b0, 0};
      vecs[1]  = '{1'b0,  0, 4, 1'b0, 0};
      vecs[2]  = '{1'b0,  0, 4, 1'b0, 0};
      vecs[3]  = '{1'b1, 11, 4, 1'b0, 0};
      vecs[4]  = '{1'b1, 12, 4, 1'b0, 0};
      vecs[5]  = '{1'b0,  0, 4, 1'b0, 0};
      vecs[6]  = '{1'b1, 13, 4, 1'b0, 0};
      vecs[7]  = '{1'b1, 14, 4, 1'b1, 10};
      vecs[8]  = '{1'b1, 15, 4, 1'b1, 11};
      vecs[9]  = '{1'b0,  0, 4, 1'b1, 0};
      vecs[10] = '{1'b1, 16, 4, 1'b1, 12};
      // delay 8 -> 3 after samples 1..12 have been streamed
      vecs[11] = '{1'b1, 13, 3, 1'b0, 0};
      vecs[12] = '{1'b1, 14, 3, 1'b0, 0};
      vecs[13] = '{1'b1, 15, 3, 1'b0, 0};
      vecs[14] = '{1'b1, 16, 3, 1'b1, 13};
      vecs[15] = '{1'b1, 17, 3, 1'b1, 14};
      vecs[16] = '{1'b0,  0, 3, 1'b1, 0};
      vecs[17] = '{1'b1, 18, 3, 1'b1, 15};

      do_reset(27, 1'b0);
      stream(27, 27, 1, 35);

      do_reset(4, 1'b0);
      for (int i = 0; i <= 10; i++)
         step(vecs[i].vld, vecs[i].val, vecs[i].dly, vecs[i].exp_pr, vecs[i].exp_out);

      do_reset(32, 1'b0);
      stream(32, 32, 1, 70);

      do_reset(0, 1'b0);
      stream(0, 1, 1, 6);

      do_reset(40, 1'b0);
      stream(40, 32, 1, 36);

      do_reset(8, 1'b0);
      stream(8, 8, 1, 12);
      for (int i = 11; i <= 17; i++)
         step(vecs[i].vld, vecs[i].val, vecs[i].dly, vecs[i].exp_pr, vecs[i].exp_out);

      // Reset asserted while samples are still arriving.
      do_reset(3, 1'b1);
      stream(3, 3, 1, 6);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
